// File: rtl/mem_bus_ctrl_if.sv
// CPU-side memory bus: command, address and store data toward the controller,
// plus load data and the ready/done handshake coming back.
interface mem_bus_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;
    logic              mem_done;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, mem_ready, mem_done
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, mem_ready, mem_done
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory/IO controller: word RAM plus LED/switch registers behind a wait-stated bus.
// Define MEM_BUS_ERR_EN to build the sticky bus_err flag for unmapped accesses.
module mem_bus_ctrl #(
    parameter int              DATA_W      = 16,
    parameter int              ADDR_W      = 9,
    parameter int              RAM_DEPTH   = 256,
    parameter int              WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
    parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140,
    parameter int              IO_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_ctrl_if.slave     bus,
    input  logic [IO_W-1:0]   sw,
    output logic [IO_W-1:0]   led,
    output logic              bus_err
);

    localparam int                RAM_AW    = $clog2(RAM_DEPTH);
    localparam logic [ADDR_W:0]   RAM_LIMIT = (ADDR_W+1)'(RAM_DEPTH);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [1:0]        CMD_READ  = 2'b01;
    localparam logic [1:0]        CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [IO_W-1:0]     led_q, led_d;
    logic [IO_W-1:0]     sw_meta_q, sw_sync_q;
    logic [DATA_W-1:0]   ram [RAM_DEPTH];
    logic                ram_we;
    logic                hit_ram, hit_led, hit_sw;
    logic [DATA_W-1:0]   rd_val;

    // Decode on the latched address; RAM wins over the IO registers.
    assign hit_ram = {1'b0, addr_q} < RAM_LIMIT;
    assign hit_led = !hit_ram && (addr_q == LED_ADDR);
    assign hit_sw  = !hit_ram && !hit_led && (addr_q == SW_ADDR);

    always_comb begin
        rd_val = '0;
        if (hit_ram)      rd_val = ram[addr_q[RAM_AW-1:0]];
        else if (hit_led) rd_val = DATA_W'(led_q);
        else if (hit_sw)  rd_val = DATA_W'(sw_sync_q);
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        led_d   = led_q;
        ram_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.mem_cmd == CMD_READ || bus.mem_cmd == CMD_WRITE) begin
                    wr_d    = (bus.mem_cmd == CMD_WRITE);
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.write_data;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                state_d = S_DONE;
                if (wr_q) begin
                    if (hit_ram)      ram_we = 1'b1;
                    else if (hit_led) led_d  = wdata_q[IO_W-1:0];
                end else begin
                    rdata_d = rd_val;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    // NOTE: RAM has no reset so it maps onto a plain memory macro; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (ram_we) ram[addr_q[RAM_AW-1:0]] <= wdata_q;
    end

    assign bus.read_data = rdata_q;
    assign bus.mem_ready = (state_q == S_IDLE);
    assign bus.mem_done  = (state_q == S_DONE);
    assign led           = led_q;

`ifdef MEM_BUS_ERR_EN
    logic bus_err_q;
    logic bad_access;

    assign bad_access = !(hit_ram || hit_led || hit_sw) || (wr_q && hit_sw);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                   bus_err_q <= 1'b0;
        else if (state_q == S_ACCESS && bad_access)   bus_err_q <= 1'b1;
    end

    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed vector table, reset-abort and
// zero-wait sequences, then random traffic against a behavioural bus model.
module tb_mem_bus_ctrl;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;
    localparam logic [1:0] CMD_RSV  = 2'b11;
    localparam logic [8:0] LED_A    = 9'h100;
    localparam logic [8:0] SW_A     = 9'h140;
    localparam int         W0       = 1;
    localparam int         W1       = 0;
`ifdef MEM_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [7:0] led0, led1;
    logic       berr0, berr1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.DATA_W(16), .ADDR_W(9)) if0 ();
    mem_bus_ctrl_if #(.DATA_W(16), .ADDR_W(9)) if1 ();

    mem_bus_ctrl #(.WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0), .sw(sw), .led(led0), .bus_err(berr0)
    );
    mem_bus_ctrl #(.WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1), .sw(sw), .led(led1), .bus_err(berr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_done(input int d);
        return (d == 0) ? if0.mem_done : if1.mem_done;
    endfunction

    function automatic logic [15:0] get_rd(input int d);
        return (d == 0) ? if0.read_data : if1.read_data;
    endfunction

    task automatic drive(input int d, input logic [1:0] cmd, input logic [8:0] addr,
                         input logic [15:0] data);
        if (d == 0) begin
            if0.mem_cmd = cmd; if0.mem_addr = addr; if0.write_data = data;
        end else begin
            if1.mem_cmd = cmd; if1.mem_addr = addr; if1.write_data = data;
        end
    endtask

    // Called #1 after a rising edge with the DUT idle. Returns the number of edges
    // from the request edge to the first cycle with mem_done high (-1 on timeout),
    // the read_data seen then, and how many done pulses occurred around it.
    task automatic do_access(input int d, input logic [1:0] cmd, input logic [8:0] addr,
                             input logic [15:0] data, output logic [15:0] rd,
                             output int lat, output int ndone);
        drive(d, cmd, addr, data);
        @(posedge clk); #1;
        drive(d, CMD_NONE, 9'($urandom), 16'($urandom));
        lat = -1; ndone = 0; rd = '0;
        for (int k = 0; k <= 40; k++) begin
            if (get_done(d)) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    rd  = get_rd(d);
                end
            end
            if (lat >= 0 && k >= lat + 2) break;
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic [7:0]  exp_led;
        logic        exp_err;
    } vec_t;

    // Behavioural model of the bus as seen by the cpu.
    logic [15:0] m_ram [256];
    bit          m_vld [256];
    logic [7:0]  m_led;
    logic [15:0] m_rd;
    bit          m_rd_known;
    bit          m_err;

    task automatic model_access(input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] wd);
        bit mapped;
        mapped = (a < 9'd256) || (a == LED_A) || (a == SW_A);
        if (cmd == CMD_WR) begin
            if (a < 9'd256) begin
                m_ram[a[7:0]] = wd; m_vld[a[7:0]] = 1'b1;
            end else if (a == LED_A) begin
                m_led = wd[7:0];
            end
            if (!mapped || a == SW_A) m_err = 1'b1;
        end else if (cmd == CMD_RD) begin
            m_rd_known = 1'b1;
            if (a < 9'd256) begin
                m_rd = m_ram[a[7:0]]; m_rd_known = m_vld[a[7:0]];
            end else if (a == LED_A) m_rd = {8'h00, m_led};
            else if (a == SW_A)      m_rd = {8'h00, sw};
            else                     m_rd = 16'h0000;
            if (!mapped) m_err = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [9];
        logic [15:0] rd;
        int          lat, nd;

        tbl[0] = '{CMD_WR, 9'h003, 16'hBEEF, 16'h0000, 8'h00, 1'b0};
        tbl[1] = '{CMD_RD, 9'h003, 16'h0000, 16'hBEEF, 8'h00, 1'b0};
        tbl[2] = '{CMD_WR, LED_A,  16'hFFA5, 16'hBEEF, 8'hA5, 1'b0};
        tbl[3] = '{CMD_RD, LED_A,  16'h0000, 16'h00A5, 8'hA5, 1'b0};
        tbl[4] = '{CMD_WR, 9'h040, 16'h5555, 16'h00A5, 8'hA5, 1'b0};
        tbl[5] = '{CMD_RD, SW_A,   16'h0000, 16'h003C, 8'hA5, 1'b0};
        tbl[6] = '{CMD_WR, SW_A,   16'h0001, 16'h003C, 8'hA5, 1'b1};
        tbl[7] = '{CMD_RD, 9'h040, 16'h0000, 16'h5555, 8'hA5, 1'b1};
        tbl[8] = '{CMD_RD, 9'h1FF, 16'h0000, 16'h0000, 8'hA5, 1'b1};

        drive(0, CMD_NONE, '0, '0);
        drive(1, CMD_NONE, '0, '0);
        sw = 8'h3C;
        #2;
        check("reset_ready", 32'(if0.mem_ready), 32'd1);
        check("reset_done",  32'(if0.mem_done),  32'd0);
        check("reset_rd",    32'(if0.read_data), 32'd0);
        check("reset_led",   32'(led0),          32'd0);
        check("reset_err",   32'(berr0),         32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed table on the one-wait-state instance.
        for (int i = 0; i < 9; i++) begin
            do_access(0, tbl[i].cmd, tbl[i].addr, tbl[i].wdata, rd, lat, nd);
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(W0 + 1));
            check($sformatf("tbl%0d_ndone", i),   32'(nd),  32'd1);
            check($sformatf("tbl%0d_rd", i),      32'(rd),  32'(tbl[i].exp_rd));
            check($sformatf("tbl%0d_led", i),     32'(led0), 32'(tbl[i].exp_led));
            check($sformatf("tbl%0d_err", i),     32'(berr0), 32'(ERR_EN & tbl[i].exp_err));
            check($sformatf("tbl%0d_ready", i),   32'(if0.mem_ready), 32'd1);
        end

        // Zero-wait-state instance: done in the cycle after the access cycle.
        do_access(1, CMD_WR, 9'h000, 16'h1234, rd, lat, nd);
        check("w0_wr_latency", 32'(lat), 32'(W1 + 1));
        do_access(1, CMD_RD, 9'h000, 16'h0000, rd, lat, nd);
        check("w0_rd_latency", 32'(lat), 32'(W1 + 1));
        check("w0_rd_ndone",   32'(nd),  32'd1);
        check("w0_rd_data",    32'(rd),  32'h1234);
        check("w0_err",        32'(berr1), 32'd0);

        // Reset in the middle of a pending write.
        do_access(0, CMD_WR, 9'h005, 16'h1111, rd, lat, nd);
        do_access(0, CMD_WR, LED_A,  16'h005A, rd, lat, nd);
        do_access(0, CMD_RD, 9'h003, 16'h0000, rd, lat, nd);
        check("abort_pre_led", 32'(led0), 32'h5A);
        drive(0, CMD_WR, 9'h005, 16'hDEAD);
        @(posedge clk); #1;
        drive(0, CMD_NONE, '0, '0);
        check("abort_in_wait", 32'(if0.mem_ready), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("abort_ready", 32'(if0.mem_ready), 32'd1);
        check("abort_rd",    32'(if0.read_data), 32'd0);
        check("abort_led",   32'(led0),          32'd0);
        check("abort_err",   32'(berr0),         32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        do_access(0, CMD_RD, 9'h005, 16'h0000, rd, lat, nd);
        check("abort_rd5",     32'(rd),   32'h1111);
        check("abort_led_after", 32'(led0), 32'd0);

        // Random traffic against the model.
        foreach (m_vld[i]) m_vld[i] = 1'b0;
        m_ram[3] = 16'hBEEF;    m_vld[3] = 1'b1;
        m_ram[5] = 16'h1111;    m_vld[5] = 1'b1;
        m_ram[8'h40] = 16'h5555; m_vld[8'h40] = 1'b1;
        m_led = 8'h00; m_rd = 16'h1111; m_rd_known = 1'b1; m_err = 1'b0;
        for (int n = 0; n < 150; n++) begin
            logic [1:0]  cmd;
            logic [8:0]  a;
            logic [15:0] wd;
            int          r;
            if ($urandom_range(0, 7) == 0) begin
                sw = 8'($urandom);
                repeat (2) begin @(posedge clk); #1; end
            end
            cmd = 2'($urandom_range(0, 3));
            r   = $urandom_range(0, 9);
            if (r < 5)       a = 9'($urandom_range(0, 15));
            else if (r == 5) a = 9'($urandom_range(0, 255));
            else if (r == 6) a = LED_A;
            else if (r == 7) a = SW_A;
            else begin
                a = 9'(256 + $urandom_range(0, 255));
                if (a == LED_A || a == SW_A) a = 9'h1FF;
            end
            wd = 16'($urandom);
            if (cmd == CMD_NONE || cmd == CMD_RSV) begin
                drive(0, cmd, a, wd);
                @(posedge clk); #1;
                drive(0, CMD_NONE, '0, '0);
                check($sformatf("rnd%0d_noreq", n), {30'd0, if0.mem_ready, if0.mem_done}, 32'b10);
            end else begin
                do_access(0, cmd, a, wd, rd, lat, nd);
                model_access(cmd, a, wd);
                check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(W0 + 1));
                check($sformatf("rnd%0d_ndone", n),   32'(nd),  32'd1);
                if (m_rd_known) check($sformatf("rnd%0d_rd", n), 32'(rd), 32'(m_rd));
                check($sformatf("rnd%0d_led", n), 32'(led0),  32'(m_led));
                check($sformatf("rnd%0d_err", n), 32'(berr0), 32'(ERR_EN & m_err));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
